// File: rtl/configurations_pkg.sv
// rtl/configurations_pkg.sv - shared vector-unit sizing plus memory streamer op and state types
package configurations_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int VECTOR_LENGTH = 1024;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } stream_state_t;

endpackage

// File: rtl/v_mem_addr_gen.sv
// rtl/v_mem_addr_gen.sv - element index counter and byte-address generator, advanced once per granted request
module v_mem_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 11,
  parameter int STRIDE     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic                  inc,
  input  logic [CNT_WIDTH-1:0]  vl,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [CNT_WIDTH-1:0]  index,
  output logic                  more,
  output logic                  last
);

  // Address arithmetic wraps modulo 2^ADDR_WIDTH by plain truncation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr  <= '0;
      index <= '0;
    end else if (load) begin
      addr  <= base;
      index <= '0;
    end else if (inc) begin
      addr  <= addr + ADDR_WIDTH'(STRIDE);
      index <= index + CNT_WIDTH'(1);
    end
  end

  assign more = (index < vl);
  assign last = (index == vl - CNT_WIDTH'(1));

endmodule

// File: rtl/v_lane_mem_streamer.sv
// rtl/v_lane_mem_streamer.sv - streams unit-stride vector loads into the lane load FIFO and drains the store FIFO to memory
module v_lane_mem_streamer #(
  parameter int DATA_WIDTH      = configurations_pkg::DATA_WIDTH,
  parameter int VECTOR_LENGTH   = configurations_pkg::VECTOR_LENGTH,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start_i,
  input  logic                                 op_i,
  input  logic [ADDR_WIDTH-1:0]                base_addr_i,
  input  logic [$clog2(VECTOR_LENGTH):0]       vector_length_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 error_o,
  output logic                                 mem_req_o,
  output logic                                 mem_we_o,
  output logic [ADDR_WIDTH-1:0]                mem_addr_o,
  output logic [DATA_WIDTH-1:0]                mem_wdata_o,
  input  logic                                 mem_gnt_i,
  input  logic [DATA_WIDTH-1:0]                mem_rdata_i,
  input  logic                                 mem_rvalid_i,
  output logic                                 load_fifo_we_o,
  output logic [DATA_WIDTH-1:0]                load_fifo_wdata_o,
  input  logic                                 load_fifo_almostfull_i,
  output logic                                 store_fifo_re_o,
  input  logic [DATA_WIDTH-1:0]                store_fifo_rdata_i,
  input  logic                                 store_fifo_empty_i
);
  import configurations_pkg::*;

  localparam int CW = $clog2(VECTOR_LENGTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  stream_state_t state, state_nx;
  logic [CW-1:0] vl_q, returned, popped;
  logic [OW-1:0] outstanding;
  logic          req_pending, rvalid_q, pop_pending, hold_valid, err_q;
  logic [DATA_WIDTH-1:0] rdata_q, hold_data;
  logic [ADDR_WIDTH-1:0] gen_addr;
  logic [CW-1:0] gen_index;
  logic          gen_more, gen_last;
  logic          accept, xfer, rd_gnt, rvalid_ok, err_set, load_req, store_req, slot_full;

  assign accept    = (state == IDLE) && start_i;
  assign xfer      = mem_req_o && mem_gnt_i;
  assign rd_gnt    = xfer && !mem_we_o;
  assign rvalid_ok = mem_rvalid_i && (state != IDLE) && (outstanding != '0);
  assign err_set   = mem_rvalid_i && ((state == IDLE) || (outstanding == '0));

  // A request already presented but not granted stays up even if almostfull rises.
  assign load_req  = (state == LOAD) &&
                     (req_pending || (gen_more && (outstanding < OW'(MAX_OUTSTANDING)) && !load_fifo_almostfull_i));

  // The single store slot holds either the element arriving from the FIFO this cycle or the captured one.
  assign slot_full = pop_pending || hold_valid;
  assign store_req = (state == STORE) && slot_full;

  assign store_fifo_re_o   = (state == STORE) && (popped < vl_q) && !store_fifo_empty_i && (!slot_full || xfer);
  assign mem_req_o         = load_req || store_req;
  assign mem_we_o          = store_req;
  assign mem_addr_o        = gen_addr;
  assign mem_wdata_o       = (pop_pending && !hold_valid) ? store_fifo_rdata_i : hold_data;
  assign load_fifo_we_o    = rvalid_q;
  assign load_fifo_wdata_o = rdata_q;
  assign busy_o            = (state != IDLE);
  assign done_o            = (state == DONE);
  assign error_o           = err_q;

  v_mem_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CW),
    .STRIDE     (DATA_WIDTH / 8)
  ) u_addr_gen (
    .clk   (clk),
    .rst_n (reset),
    .load  (accept),
    .base  (base_addr_i),
    .inc   (xfer),
    .vl    (vl_q),
    .addr  (gen_addr),
    .index (gen_index),
    .more  (gen_more),
    .last  (gen_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start_i) begin
               if (vector_length_i == '0)     state_nx = DONE;
               else if (op_i == MEM_STORE)    state_nx = STORE;
               else                           state_nx = LOAD;
             end
      LOAD:  if (rvalid_q && (returned == vl_q - CW'(1))) state_nx = DONE;
      STORE: if (xfer && gen_last)                        state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vl_q        <= '0;
      returned    <= '0;
      popped      <= '0;
      outstanding <= '0;
      req_pending <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      pop_pending <= 1'b0;
      hold_valid  <= 1'b0;
      hold_data   <= '0;
      err_q       <= 1'b0;
    end else begin
      req_pending <= load_req && !mem_gnt_i;
      rvalid_q    <= rvalid_ok;
      if (rvalid_ok) rdata_q <= mem_rdata_i;
      pop_pending <= store_fifo_re_o;
      if (store_req && xfer) begin
        hold_valid <= 1'b0;
      end else if (pop_pending) begin
        hold_valid <= 1'b1;
        hold_data  <= store_fifo_rdata_i;
      end
      if (err_set)     err_q <= 1'b1;
      else if (accept) err_q <= 1'b0;
      if (accept) begin
        vl_q        <= vector_length_i;
        returned    <= '0;
        popped      <= '0;
        outstanding <= '0;
      end else begin
        if (rvalid_q)        returned <= returned + CW'(1);
        if (store_fifo_re_o) popped   <= popped + CW'(1);
        unique case ({rd_gnt, rvalid_ok})
          2'b10:   outstanding <= outstanding + OW'(1);
          2'b01:   outstanding <= outstanding - OW'(1);
          default: outstanding <= outstanding;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_v_lane_mem_streamer.sv
// tb/tb_v_lane_mem_streamer.sv - directed self-checking bench for v_lane_mem_streamer
module tb_v_lane_mem_streamer;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, op = 1'b0, af = 1'b0, force_rv = 1'b0;
  logic          gnt_toggle = 1'b0, gnt_const = 1'b1;
  logic [AW-1:0] base = '0;
  logic [CW-1:0] vlen = '0;
  logic          busy, done, err, req, we, gnt, rvalid, lf_we, sf_re, sf_empty;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata, lf_wdata, sf_rdata;

  int checks = 0, errors = 0;
  int cyc = 0;

  logic [1:0]    pv;
  logic [AW-1:0] pa0, pa1;
  int            cur_out;
  logic [DW-1:0] sf_mem [64];
  logic [5:0]    sf_wr = '0, sf_rd;
  logic [DW-1:0] sf_rd_q;
  int            n_pops;

  int n_push = 0, n_done = 0, n_busy = 0, n_req = 0, af_viol = 0, unstable = 0, max_out = 0;
  int last_push_cyc = 0, done_cyc = 0;
  logic          prev_hold = 1'b0, prev_we = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_wdata = '0;
  logic [DW-1:0] push_q[$];
  logic [AW-1:0] gaddr_q[$];
  logic [DW-1:0] gdata_q[$];

  assign gnt      = gnt_toggle ? cyc[0] : gnt_const;
  assign rvalid   = pv[1] | force_rv;
  assign rdata    = pa1 ^ 32'hA5A5_0000;
  assign sf_empty = (sf_rd == sf_wr);
  assign sf_rdata = sf_rd_q;

  v_lane_mem_streamer dut (
    .clk                    (clk),
    .reset                  (rst_n),
    .start_i                (start),
    .op_i                   (op),
    .base_addr_i            (base),
    .vector_length_i        (vlen),
    .busy_o                 (busy),
    .done_o                 (done),
    .error_o                (err),
    .mem_req_o              (req),
    .mem_we_o               (we),
    .mem_addr_o             (addr),
    .mem_wdata_o            (wdata),
    .mem_gnt_i              (gnt),
    .mem_rdata_i            (rdata),
    .mem_rvalid_i           (rvalid),
    .load_fifo_we_o         (lf_we),
    .load_fifo_wdata_o      (lf_wdata),
    .load_fifo_almostfull_i (af),
    .store_fifo_re_o        (sf_re),
    .store_fifo_rdata_i     (sf_rdata),
    .store_fifo_empty_i     (sf_empty)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Memory returns read data two cycles after the grant; store FIFO presents data the cycle after a pop.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0; pa0 <= '0; pa1 <= '0; cur_out <= 0;
      sf_rd <= '0; sf_rd_q <= '0; n_pops <= 0;
    end else begin
      pv  <= {pv[0], req & gnt & ~we};
      pa0 <= addr;
      pa1 <= pa0;
      cur_out <= cur_out + ((req & gnt & ~we) ? 1 : 0) - ((rvalid && cur_out != 0) ? 1 : 0);
      if (sf_re) begin
        sf_rd_q <= sf_mem[sf_rd];
        sf_rd   <= sf_rd + 6'd1;
        n_pops  <= n_pops + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (lf_we) begin n_push++; push_q.push_back(lf_wdata); last_push_cyc = cyc; end
    if (done) begin n_done++; done_cyc = cyc; end
    if (busy) n_busy++;
    if (req) n_req++;
    if (req && gnt) begin
      gaddr_q.push_back(addr);
      if (we) gdata_q.push_back(wdata);
    end
    if (af && req && !we) af_viol++;
    if (prev_hold && (req !== 1'b1 || we !== prev_we || addr !== prev_addr || wdata !== prev_wdata)) unstable++;
    prev_hold  = req && !gnt;
    prev_we    = we;
    prev_addr  = addr;
    prev_wdata = wdata;
    if (cur_out > max_out) max_out = cur_out;
  end

  task automatic run_cmd(input logic o, input logic [AW-1:0] b, input logic [CW-1:0] v,
                         input int budget, input string name);
    int d0, n;
    d0 = n_done;
    @(posedge clk); #1;
    start = 1'b1; op = o; base = b; vlen = v;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (n_done == d0 && n < budget) begin @(posedge clk); #1; n++; end
    checks++;
    if (n_done == d0) begin
      errors++;
      $display("FAIL %s_timeout: done_o not seen after %0d cycles", name, budget);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, done, err, req, we, lf_we, sf_re} !== 7'b0 || addr !== '0 || wdata !== '0 || lf_wdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ctl=%b addr=%h wdata=%h lfw=%h, want all zero",
               {busy, done, err, req, we, lf_we, sf_re}, addr, wdata, lf_wdata);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy_o=%b want 0", busy); end
  endtask

  task automatic test_load_basic();
    int p0, a0, d0;
    p0 = n_push; a0 = gaddr_q.size(); d0 = n_done;
    run_cmd(1'b0, 32'h100, 11'd8, 200, "load8");
    checks++;
    if (n_push - p0 != 8) begin errors++; $display("FAIL load8_pushes: got %0d want 8", n_push - p0); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (gaddr_q[a0+k] !== 32'h100 + 32'(4*k)) begin
        errors++; $display("FAIL load8_addr[%0d]: got %h want %h", k, gaddr_q[a0+k], 32'h100 + 32'(4*k));
      end
      checks++;
      if (push_q[p0+k] !== ((32'h100 + 32'(4*k)) ^ 32'hA5A5_0000)) begin
        errors++; $display("FAIL load8_data[%0d]: got %h want %h", k, push_q[p0+k], (32'h100 + 32'(4*k)) ^ 32'hA5A5_0000);
      end
    end
    checks++;
    if (n_done - d0 != 1) begin errors++; $display("FAIL load8_done_count: got %0d want 1", n_done - d0); end
    checks++;
    if (done_cyc != last_push_cyc + 1) begin
      errors++; $display("FAIL load8_done_timing: done cycle %0d want %0d", done_cyc, last_push_cyc + 1);
    end
  endtask

  task automatic test_almostfull();
    int p0, v0, d0, c;
    p0 = n_push; v0 = af_viol; d0 = n_done;
    @(posedge clk); #1;
    start = 1'b1; op = 1'b0; base = 32'h400; vlen = 11'd16;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (n_done == d0 && c < 300) begin
      af = (c >= 3 && c <= 10);
      @(posedge clk); #1;
      c++;
    end
    af = 1'b0;
    checks++;
    if (n_done == d0) begin errors++; $display("FAIL af_timeout: done_o not seen"); end
    checks++;
    if (af_viol != v0) begin errors++; $display("FAIL af_req_while_full: got %0d requests want 0", af_viol - v0); end
    checks++;
    if (max_out > 4) begin errors++; $display("FAIL af_outstanding: got %0d want <=4", max_out); end
    checks++;
    if (n_push - p0 != 16) begin errors++; $display("FAIL af_pushes: got %0d want 16", n_push - p0); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (push_q[p0+k] !== ((32'h400 + 32'(4*k)) ^ 32'hA5A5_0000)) begin
        errors++; $display("FAIL af_data[%0d]: got %h want %h", k, push_q[p0+k], (32'h400 + 32'(4*k)) ^ 32'hA5A5_0000);
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_store();
    logic [DW-1:0] vals [4];
    int a0, g0, u0, q0;
    vals[0] = 32'hAAAA_0001; vals[1] = 32'hBBBB_0002; vals[2] = 32'hCCCC_0003; vals[3] = 32'hDDDD_0004;
    for (int k = 0; k < 4; k++) begin
      sf_mem[sf_wr] = vals[k];
      sf_wr = sf_wr + 6'd1;
    end
    a0 = gaddr_q.size(); g0 = gdata_q.size(); u0 = unstable; q0 = n_pops;
    gnt_toggle = 1'b1;
    run_cmd(1'b1, 32'h200, 11'd4, 100, "store4");
    gnt_toggle = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (gdata_q[g0+k] !== vals[k]) begin
        errors++; $display("FAIL store_wdata[%0d]: got %h want %h", k, gdata_q[g0+k], vals[k]);
      end
      checks++;
      if (gaddr_q[a0+k] !== 32'h200 + 32'(4*k)) begin
        errors++; $display("FAIL store_addr[%0d]: got %h want %h", k, gaddr_q[a0+k], 32'h200 + 32'(4*k));
      end
    end
    checks++;
    if (unstable != u0) begin errors++; $display("FAIL store_stable: got %0d changes while ungranted want 0", unstable - u0); end
    checks++;
    if (n_pops - q0 != 4) begin errors++; $display("FAIL store_pops: got %0d want 4", n_pops - q0); end
  endtask

  task automatic test_zero_and_full();
    int b0, r0, d0, p0;
    b0 = n_busy; r0 = n_req; d0 = n_done;
    run_cmd(1'b1, 32'h300, 11'd0, 20, "vl0");
    checks++;
    if (n_busy - b0 != 1) begin errors++; $display("FAIL vl0_busy_cycles: got %0d want 1", n_busy - b0); end
    checks++;
    if (n_done - d0 != 1) begin errors++; $display("FAIL vl0_done: got %0d want 1", n_done - d0); end
    checks++;
    if (n_req != r0) begin errors++; $display("FAIL vl0_req: got %0d request cycles want 0", n_req - r0); end
    p0 = n_push;
    run_cmd(1'b0, 32'h0, 11'd1024, 4000, "vl1024");
    checks++;
    if (n_push - p0 != 1024) begin errors++; $display("FAIL vl1024_pushes: got %0d want 1024", n_push - p0); end
    checks++;
    if (push_q[p0+1023] !== (32'd4092 ^ 32'hA5A5_0000)) begin
      errors++; $display("FAIL vl1024_last_data: got %h want %h", push_q[p0+1023], 32'd4092 ^ 32'hA5A5_0000);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [4];
    int a0;
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000; exp_a[3] = 32'h0000_0004;
    a0 = gaddr_q.size();
    run_cmd(1'b0, 32'hFFFF_FFF8, 11'd4, 100, "wrap");
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (gaddr_q[a0+k] !== exp_a[k]) begin
        errors++; $display("FAIL wrap_addr[%0d]: got %h want %h", k, gaddr_q[a0+k], exp_a[k]);
      end
    end
  endtask

  task automatic test_reset_midload();
    int p0, d0, n;
    p0 = n_push; d0 = n_done;
    @(posedge clk); #1;
    start = 1'b1; op = 1'b0; base = 32'h300; vlen = 11'd8;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (n_push - p0 < 3 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n_push - p0 != 3) begin errors++; $display("FAIL midreset_progress: got %0d pushes want 3", n_push - p0); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, req, we, lf_we, sf_re} !== 7'b0 || addr !== '0 || wdata !== '0 || lf_wdata !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got ctl=%b addr=%h wdata=%h lfw=%h, want all zero",
               {busy, done, err, req, we, lf_we, sf_re}, addr, wdata, lf_wdata);
    end
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (n_done != d0) begin errors++; $display("FAIL midreset_done: got %0d pulses want 0", n_done - d0); end
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL midreset_idle: busy=%b err=%b want 0 0", busy, err); end
    p0 = n_push;
    force_rv = 1'b1;
    @(posedge clk); #1;
    force_rv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL spurious_error: error_o=%b want 1", err); end
    checks++;
    if (n_push != p0) begin errors++; $display("FAIL spurious_push: got %0d pushes want 0", n_push - p0); end
    run_cmd(1'b1, 32'h0, 11'd0, 20, "errclr");
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL error_clear: error_o=%b want 0", err); end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_almostfull();
    test_store();
    test_zero_and_full();
    test_wrap();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
